// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcodes, fetch FSM encoding, default XLEN.
// FETCH_MISALIGN_CHECK_EN adds the HALT state used after a misaligned redirect.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned OPC_W        = 7;

  // Major opcodes decoded by the main controller
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_HOLD = 3'd2,
    ST_KILL = 3'd3
`ifdef FETCH_MISALIGN_CHECK_EN
    , ST_HALT = 3'd4
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decode handshake, redirect.
import riscv_pkg::*;

interface fetch_unit_if #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) ();
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_rsp_valid;
  logic [XLEN-1:0]  imem_rdata;
  logic [XLEN-1:0]  instr;
  logic [OPC_W-1:0] opc;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic             instr_valid;
  logic             instr_ready;
  logic             redirect;
  logic [XLEN-1:0]  redirect_target;
  logic             misalign;

  modport master (
    output imem_req, imem_addr, instr, opc, pc, pc_plus4, instr_valid, misalign,
    input  imem_rsp_valid, imem_rdata, instr_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, opc, pc, pc_plus4, instr_valid, misalign,
    output imem_rsp_valid, imem_rdata, instr_ready, redirect, redirect_target
  );
endinterface

// File: rtl/pc_register.sv
// Program counter register with load enable and asynchronous reset to RESET_PC.
module pc_register #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= RESET_PC;
    else if (load) q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, instruction register, redirects.
// FETCH_MISALIGN_CHECK_EN: misaligned redirect targets set sticky misalign and halt fetch.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master fif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, target_c;
  logic            pc_load, instr_load;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_set, bad_target_c;
  assign target_c     = fif.redirect_target;
  assign bad_target_c = |fif.redirect_target[1:0];
`else
  // Low address bits are dropped so every target is word aligned
  assign target_c = fif.redirect_target & ~XLEN'(3);
`endif

  pc_register #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    pc_d       = pc_q;
    instr_load = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (fif.redirect) begin
          pc_load = 1'b1;
          pc_d    = target_c;
          state_d = fif.imem_rsp_valid ? ST_REQ : ST_KILL;
        end else if (fif.imem_rsp_valid) begin
          instr_load = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      ST_KILL: begin
        if (fif.redirect) begin
          pc_load = 1'b1;
          pc_d    = target_c;
        end
        if (fif.imem_rsp_valid) state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (fif.redirect) begin
          pc_load = 1'b1;
          pc_d    = target_c;
          state_d = ST_REQ;
        end else if (fif.instr_ready) begin
          pc_load = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = ST_REQ;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    // A misaligned target overrides every redirect action: nothing is loaded
    if (fif.redirect && bad_target_c &&
        (state_q == ST_REQ || state_q == ST_KILL || state_q == ST_HOLD)) begin
      pc_load      = 1'b0;
      instr_load   = 1'b0;
      misalign_set = 1'b1;
      state_d      = ST_HALT;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             instr_q <= '0;
    else if (instr_load) instr_q <= fif.imem_rdata;
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               misalign_q <= 1'b0;
    else if (misalign_set) misalign_q <= 1'b1;
  end
  assign fif.misalign = misalign_q;
`else
  assign fif.misalign = 1'b0;
`endif

  assign fif.imem_req    = (state_q == ST_REQ);
  assign fif.imem_addr   = pc_q;
  assign fif.instr_valid = (state_q == ST_HOLD);
  assign fif.instr       = instr_q;
  assign fif.opc         = instr_q[OPC_W-1:0];
  assign fif.pc          = pc_q;
  assign fif.pc_plus4    = pc_q + XLEN'(4);

endmodule
